// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch holds,
// EX redirects, data-memory waits with timeout trap, and perf counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req_load,
  input  logic             stall_branch,
  input  logic             ex_mispredict,
  input  logic [31:0]      ex_target,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic [4:0]       stall,
  output logic [4:0]       flush,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);

  state_t          state, state_n;
  logic [WW-1:0]   wait_cnt, wait_n;
  logic            pend_valid, pend_valid_n;
  logic [31:0]     pend_pc, pend_pc_n;
  logic            err_q, err_n;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic [4:0]  st, fl;
  logic        redir;
  logic [31:0] rpc;

  always_comb begin
    state_n      = state;
    wait_n       = wait_cnt;
    pend_valid_n = pend_valid;
    pend_pc_n    = pend_pc;
    err_n        = err_q;
    st           = 5'b00000;
    fl           = 5'b00000;
    redir        = 1'b0;
    rpc          = 32'h0;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ack) begin
          st      = 5'b01111;
          fl      = 5'b10000;
          state_n = MEM_WAIT;
          wait_n  = WW'(1);
          if (ex_mispredict && !pend_valid) begin
            pend_valid_n = 1'b1;
            pend_pc_n    = ex_target;
          end
        end else if (pend_valid) begin
          redir        = 1'b1;
          rpc          = pend_pc;
          fl           = 5'b00110;
          pend_valid_n = 1'b0;
        end else if (ex_mispredict) begin
          // wrong-path load-use / branch holds are discarded
          redir = 1'b1;
          rpc   = ex_target;
          fl    = 5'b00110;
        end else if (stall_req_load) begin
          st = 5'b00011;
          fl = 5'b00100;
        end else if (stall_branch) begin
          st = 5'b00001;
          fl = 5'b00010;
        end
      end
      MEM_WAIT: begin
        st = 5'b01111;
        fl = 5'b10000;
        if (ex_mispredict && !pend_valid) begin
          pend_valid_n = 1'b1;
          pend_pc_n    = ex_target;
        end
        if (mem_ack) begin
          state_n = RUN;
          wait_n  = '0;
        end else begin
          wait_n = wait_cnt + WW'(1);
          if (wait_cnt == LAST) begin
            state_n = ERROR;
            err_n   = 1'b1;
          end
        end
      end
      ERROR: begin
        st = 5'b11111;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wait_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
      err_q      <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_n;
      pend_valid <= pend_valid_n;
      pend_pc    <= pend_pc_n;
      err_q      <= err_n;
      if (st[0] && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (redir && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  // all outputs read zero while reset is held
  assign stall        = rst ? 5'b0 : st;
  assign flush        = rst ? 5'b0 : fl;
  assign pc_redirect  = rst ? 1'b0 : redir;
  assign redirect_pc  = rst ? 32'h0 : rpc;
  assign mem_err      = rst ? 1'b0 : err_q;
  assign stall_cycles = rst ? '0 : stall_q;
  assign flush_count  = rst ? '0 : flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_load, stall_branch, ex_mispredict;
  logic [31:0] ex_target;
  logic        mem_req, mem_ack;
  logic [4:0]  stall, flush;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        mem_err;
  logic [31:0] stall_cycles, flush_count;

  int vectors = 0;
  int errors  = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .stall_req_load(stall_req_load), .stall_branch(stall_branch),
    .ex_mispredict(ex_mispredict), .ex_target(ex_target),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .stall(stall), .flush(flush),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall_req_load = 0; stall_branch = 0; ex_mispredict = 0;
    ex_target = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); rst = 0;
  endtask

  task automatic chk_sf(input string tag, input logic [4:0] s,
                        input logic [4:0] f);
    check({tag, "_stall"}, 32'(stall), 32'(s));
    check({tag, "_flush"}, 32'(flush), 32'(f));
  endtask

  initial begin
    rst = 1; idle();
    stall_req_load = 1;
    sample();
    chk_sf("rst", 5'b00000, 5'b00000);
    check("rst_err", 32'(mem_err), 0);
    check("rst_scyc", stall_cycles, 0);
    tick(); tick();
    rst = 0; idle();

    // load-use
    stall_req_load = 1; sample();
    chk_sf("lu", 5'b00011, 5'b00100);
    tick(); idle(); sample();
    check("lu_scyc", stall_cycles, 1);
    chk_sf("lu_after", 5'b00000, 5'b00000);

    // branch hold
    do_reset();
    stall_branch = 1; sample();
    chk_sf("br", 5'b00001, 5'b00010);

    // mispredict beats load-use and branch hold
    do_reset();
    ex_mispredict = 1; ex_target = 32'h40;
    stall_req_load = 1; stall_branch = 1; sample();
    check("mp_redir", 32'(pc_redirect), 1);
    check("mp_pc", redirect_pc, 32'h40);
    chk_sf("mp", 5'b00000, 5'b00110);
    tick(); idle(); sample();
    check("mp_fcnt", flush_count, 1);
    check("mp_pc0", redirect_pc, 0);
    check("mp_scyc", stall_cycles, 0);

    // mem_req acked same cycle: no stall
    do_reset();
    mem_req = 1; mem_ack = 1; sample();
    chk_sf("ack0", 5'b00000, 5'b00000);

    // mem wait, ack on 4th cycle
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3); sample();
      chk_sf($sformatf("mw%0d", i), 5'b01111, 5'b10000);
      check($sformatf("mw%0d_redir", i), 32'(pc_redirect), 0);
      tick();
    end
    idle(); sample();
    chk_sf("mw_done", 5'b00000, 5'b00000);
    check("mw_scyc", stall_cycles, 4);

    // mispredict during wait is deferred to one pulse after ack
    do_reset();
    mem_req = 1; sample(); tick();
    ex_mispredict = 1; ex_target = 32'h80; sample();
    check("pd_w1_redir", 32'(pc_redirect), 0);
    tick();
    mem_ack = 1; sample();
    check("pd_w2_redir", 32'(pc_redirect), 0);
    chk_sf("pd_w2", 5'b01111, 5'b10000);
    tick(); idle(); sample();
    check("pd_redir", 32'(pc_redirect), 1);
    check("pd_pc", redirect_pc, 32'h80);
    chk_sf("pd", 5'b00000, 5'b00110);
    tick(); sample();
    check("pd_once", 32'(pc_redirect), 0);
    check("pd_fcnt", flush_count, 1);
    check("pd_scyc", stall_cycles, 3);

    // timeout trap
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk_sf($sformatf("to%0d", i), 5'b01111, 5'b10000);
      check($sformatf("to%0d_err", i), 32'(mem_err), 0);
      tick();
    end
    sample();
    chk_sf("err", 5'b11111, 5'b00000);
    check("err_flag", 32'(mem_err), 1);
    check("err_scyc", stall_cycles, 4);
    mem_ack = 1; tick(); sample();
    check("err_hold", 32'(mem_err), 1);
    check("err_hold_st", 32'(stall), 32'h1f);
    check("err_scyc2", stall_cycles, 5);
    rst = 1; sample();
    chk_sf("err_rst", 5'b00000, 5'b00000);
    check("err_rst_err", 32'(mem_err), 0);
    check("err_rst_scyc", stall_cycles, 0);
    tick(); rst = 0; idle(); sample();
    check("err_run_err", 32'(mem_err), 0);
    chk_sf("err_run", 5'b00000, 5'b00000);

    // reset with a pending redirect drops it
    do_reset();
    mem_req = 1; sample(); tick();
    ex_mispredict = 1; ex_target = 32'hc0; sample(); tick();
    rst = 1; idle(); tick(); rst = 0; sample();
    check("rp_redir", 32'(pc_redirect), 0);
    check("rp_scyc", stall_cycles, 0);
    check("rp_fcnt", flush_count, 0);
    chk_sf("rp", 5'b00000, 5'b00000);
    tick(); sample();
    check("rp_redir2", 32'(pc_redirect), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
